// File: rtl/instruction_decode_pkg.sv
// ---------------------------------------------------------------------------
// instruction_decode_pkg
//   Shared ISA definitions for the fetch / decode / execute pipeline:
//   opcode encoding, instruction field layout, register-file geometry and
//   the execute bundle carried by the ID/EX pipeline register.
// ---------------------------------------------------------------------------
package instruction_decode_pkg;

    localparam int INSTR_W  = 8;   // instruction width
    localparam int NUM_REGS = 8;   // architectural registers
    localparam int REG_W    = 8;   // register width
    localparam int REG_AW   = 3;   // register index width
    localparam int OFFS_W   = 6;   // jump offset width

    // Instruction field bit positions
    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int RS_HI  = 2;
    localparam int RS_LO  = 0;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_LDI = 2'b10,
        OP_JMP = 2'b11
    } opcode_e;

    // [7:6] opcode, [5:3] rd, [2:0] rs/imm3. For JMP, {rd,rs} is the offset.
    typedef struct packed {
        opcode_e           op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
    } instr_t;

    typedef struct packed {
        logic              valid;
        opcode_e           op;
        logic [REG_AW-1:0] rd;
        logic [REG_W-1:0]  a;
        logic [REG_W-1:0]  b;
    } ex_bundle_t;

endpackage

// File: rtl/instruction_decode_if.sv
// ---------------------------------------------------------------------------
// instruction_decode_if
//   Bus bundle around the decode stage.
//   Fetch side : Instruction_Code (in), mux_jump / jump_adress (out)
//   Writeback  : wb_en, wb_addr, wb_data (in)
//   Execute    : ex_valid, ex_op, ex_rd, ex_a, ex_b (out)
//   slave  = the decode stage; master = its surroundings (fetch/exec/wb).
// ---------------------------------------------------------------------------
interface instruction_decode_if;
    import instruction_decode_pkg::*;

    logic [INSTR_W-1:0] Instruction_Code;
    logic               wb_en;
    logic [REG_AW-1:0]  wb_addr;
    logic [REG_W-1:0]   wb_data;
    logic               mux_jump;
    logic [OFFS_W-1:0]  jump_adress;
    logic               ex_valid;
    logic [1:0]         ex_op;
    logic [REG_AW-1:0]  ex_rd;
    logic [REG_W-1:0]   ex_a;
    logic [REG_W-1:0]   ex_b;

    modport slave (
        input  Instruction_Code, wb_en, wb_addr, wb_data,
        output mux_jump, jump_adress, ex_valid, ex_op, ex_rd, ex_a, ex_b
    );

    modport master (
        output Instruction_Code, wb_en, wb_addr, wb_data,
        input  mux_jump, jump_adress, ex_valid, ex_op, ex_rd, ex_a, ex_b
    );

endinterface

// File: rtl/instruction_decode_reg_file.sv
// ---------------------------------------------------------------------------
// instruction_decode_reg_file
//   8 x 8 register file, async active-low reset, one synchronous write port,
//   two asynchronous read ports with write-through bypass.
//   Ports:
//     clk, reset            clock / async active-low reset
//     we_i, waddr_i, wdata_i write port
//     raddr_a_i, rdata_a_o   read port A
//     raddr_b_i, rdata_b_o   read port B
// ---------------------------------------------------------------------------
module instruction_decode_reg_file
    import instruction_decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [REG_W-1:0]  wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [REG_W-1:0]  rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [REG_W-1:0]  rdata_b_o
);

    logic [NUM_REGS-1:0][REG_W-1:0] regs_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs_q <= '0;
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle write to the index being read wins, so the consumer sees
    // the value that will be in the array after this edge.
    assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule

// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//   Second pipeline stage. Registers the fetched instruction (IF/ID),
//   decodes it, reads two operands and presents a registered execute bundle
//   (ID/EX). A valid JMP in IF/ID drives mux_jump/jump_adress back to fetch
//   and squashes the wrong-path instruction captured on the following edge.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low
//     bus    instruction_decode_if.slave (fetch, writeback, execute signals)
// ---------------------------------------------------------------------------
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    instruction_decode_if.slave  bus
);

    instr_t           id_instr_q, id_instr_d;
    logic             id_valid_q, id_valid_d;
    ex_bundle_t       ex_q, ex_d;
    logic [REG_W-1:0] rdata_a, rdata_b;
    logic             mux_jump;

    // ---------------- IF/ID ----------------
    assign mux_jump   = id_valid_q && (id_instr_q.op == OP_JMP);
    assign id_instr_d = instr_t'(bus.Instruction_Code);
    // Whatever fetch presents while a jump is being taken is wrong-path.
    // Since a squashed JMP cannot raise mux_jump, it never fires twice in a row.
    assign id_valid_d = ~mux_jump;

    // ---------------- operand read ----------------
    instruction_decode_reg_file u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .we_i      (bus.wb_en),
        .waddr_i   (bus.wb_addr),
        .wdata_i   (bus.wb_data),
        .raddr_a_i (id_instr_q.rd),
        .rdata_a_o (rdata_a),
        .raddr_b_i (id_instr_q.rs),
        .rdata_b_o (rdata_b)
    );

    // ---------------- decode -> ID/EX ----------------
    // Payload fields only load for real instructions; on a bubble they keep
    // their previous contents and only valid drops.
    always_comb begin
        ex_d       = ex_q;
        ex_d.valid = id_valid_q && (id_instr_q.op != OP_JMP);
        if (ex_d.valid) begin
            ex_d.op = id_instr_q.op;
            ex_d.rd = id_instr_q.rd;
            if (id_instr_q.op == OP_LDI) begin
                ex_d.a = '0;
                ex_d.b = REG_W'(id_instr_q.rs);
            end else begin
                ex_d.a = rdata_a;
                ex_d.b = rdata_b;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_instr_q <= '0;
            id_valid_q <= 1'b0;
            ex_q       <= '0;
        end else begin
            id_instr_q <= id_instr_d;
            id_valid_q <= id_valid_d;
            ex_q       <= ex_d;
        end
    end

    // ---------------- outputs ----------------
    assign bus.mux_jump    = mux_jump;
    assign bus.jump_adress = {id_instr_q.rd, id_instr_q.rs};
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_op       = ex_q.op;
    assign bus.ex_rd       = ex_q.rd;
    assign bus.ex_a        = ex_q.a;
    assign bus.ex_b        = ex_q.b;

endmodule

// File: tb/tb_instruction_decode.sv
// ---------------------------------------------------------------------------
// tb_instruction_decode
//   Drives the decode stage from a small fetch model (pc + instruction
//   memory) and compares every cycle against an instruction-level reference
//   model; directed programs cover the listed scenarios, then random
//   programs and writebacks.
// ---------------------------------------------------------------------------
module tb_instruction_decode;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_decode_if bus();

    instruction_decode dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    // fetch model
    logic [7:0] mem [256];
    logic [7:0] pc;

    // reference model state
    logic [7:0] m_R [8];
    logic [7:0] m_id_instr;
    logic       m_id_valid;
    logic       m_ex_valid;
    logic [1:0] m_ex_op;
    logic [2:0] m_ex_rd;
    logic [7:0] m_ex_a, m_ex_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rd_reg(input logic [2:0] idx);
        if (bus.wb_en && bus.wb_addr == idx) return bus.wb_data;
        return m_R[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_R[i] = 8'h00;
        m_id_instr = 8'h00;
        m_id_valid = 1'b0;
        m_ex_valid = 1'b0;
        m_ex_op    = 2'b00;
        m_ex_rd    = 3'd0;
        m_ex_a     = 8'h00;
        m_ex_b     = 8'h00;
        pc         = 8'h00;
    endtask

    // One rising edge of the stage, described per instruction semantics.
    task automatic model_edge();
        logic [1:0] op;
        logic [2:0] rd, rs;
        logic       jmp;
        logic [7:0] offs;
        op   = m_id_instr[7:6];
        rd   = m_id_instr[5:3];
        rs   = m_id_instr[2:0];
        jmp  = m_id_valid && op == 2'b11;
        offs = {{2{m_id_instr[5]}}, m_id_instr[5:0]};
        m_ex_valid = m_id_valid && op != 2'b11;
        if (m_ex_valid) begin
            m_ex_op = op;
            m_ex_rd = rd;
            if (op == 2'b10) begin
                m_ex_a = 8'h00;
                m_ex_b = {5'b0, rs};
            end else begin
                m_ex_a = rd_reg(rd);
                m_ex_b = rd_reg(rs);
            end
        end
        if (bus.wb_en) m_R[bus.wb_addr] = bus.wb_data;
        m_id_instr = bus.Instruction_Code;
        m_id_valid = !jmp;
        // during the jump cycle fetch already sits at p+1
        pc = jmp ? pc + offs : pc + 8'd1;
    endtask

    task automatic check_model();
        logic exp_mj;
        exp_mj = m_id_valid && m_id_instr[7:6] == 2'b11;
        chk("mux_jump",    32'(bus.mux_jump),    32'(exp_mj));
        chk("jump_adress", 32'(bus.jump_adress), 32'(m_id_instr[5:0]));
        chk("ex_valid",    32'(bus.ex_valid),    32'(m_ex_valid));
        chk("ex_op",       32'(bus.ex_op),       32'(m_ex_op));
        chk("ex_rd",       32'(bus.ex_rd),       32'(m_ex_rd));
        chk("ex_a",        32'(bus.ex_a),        32'(m_ex_a));
        chk("ex_b",        32'(bus.ex_b),        32'(m_ex_b));
    endtask

    // Drive at the falling edge, let one rising edge pass, check at the next fall.
    task automatic step(input logic we, input logic [2:0] wa, input logic [7:0] wd);
        bus.Instruction_Code = mem[pc];
        bus.wb_en   = we;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_mux_jump"}, 32'(bus.mux_jump),    32'd0);
        chk({tag, "_jadr"},     32'(bus.jump_adress), 32'd0);
        chk({tag, "_ex_valid"}, 32'(bus.ex_valid),    32'd0);
        chk({tag, "_ex_op"},    32'(bus.ex_op),       32'd0);
        chk({tag, "_ex_rd"},    32'(bus.ex_rd),       32'd0);
        chk({tag, "_ex_a"},     32'(bus.ex_a),        32'd0);
        chk({tag, "_ex_b"},     32'(bus.ex_b),        32'd0);
    endtask

    // Called just after a falling edge: assert reset well before the next
    // rising edge, check outputs cleared without any edge, release later.
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check_zero(tag);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.Instruction_Code = 8'h00;
        bus.wb_en   = 1'b0;
        bus.wb_addr = 3'd0;
        bus.wb_data = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        model_reset();

        // directed program
        mem[0]  = 8'hA5;   // LDI r4,5
        mem[1]  = 8'h1B;   // ADD r3,r3
        mem[2]  = 8'h4A;   // SUB r1,r2
        mem[3]  = 8'hC4;   // JMP +4 -> target 8
        mem[4]  = 8'hC1;   // wrong path, squashed (a JMP that must not fire)
        mem[8]  = 8'hBB;   // LDI r7,3
        mem[9]  = 8'hFF;   // JMP -1 self-loop

        repeat (2) @(negedge clk);
        check_zero("por");
        reset = 1'b1;

        step(1'b1, 3'd3, 8'hA5);           // edge1: LDI captured, r3<=A5
        chk("e1_ex_valid", 32'(bus.ex_valid), 32'd0);
        step(1'b1, 3'd2, 8'h10);           // edge2: LDI on ex, r2<=10
        chk("ldi_valid", 32'(bus.ex_valid), 32'd1);
        chk("ldi_op",    32'(bus.ex_op),    32'd2);
        chk("ldi_rd",    32'(bus.ex_rd),    32'd4);
        chk("ldi_a",     32'(bus.ex_a),     32'd0);
        chk("ldi_b",     32'(bus.ex_b),     32'h05);
        step(1'b0, 3'd0, 8'h00);           // edge3: ADD r3,r3
        chk("add_valid", 32'(bus.ex_valid), 32'd1);
        chk("add_op",    32'(bus.ex_op),    32'd0);
        chk("add_rd",    32'(bus.ex_rd),    32'd3);
        chk("add_a",     32'(bus.ex_a),     32'hA5);
        chk("add_b",     32'(bus.ex_b),     32'hA5);
        step(1'b1, 3'd2, 8'h7E);           // edge4: SUB r1,r2 with bypass on r2
        chk("sub_op",    32'(bus.ex_op),    32'd1);
        chk("byp_b",     32'(bus.ex_b),     32'h7E);
        chk("sub_a",     32'(bus.ex_a),     32'd0);
        chk("jmp_mj",    32'(bus.mux_jump), 32'd1);
        chk("jmp_adr",   32'(bus.jump_adress), 32'h04);
        step(1'b1, 3'd5, 8'h33);           // edge5: wrong path captured, r5<=33
        chk("jmp_n1_mj",    32'(bus.mux_jump), 32'd0);
        chk("jmp_n1_valid", 32'(bus.ex_valid), 32'd0);
        step(1'b0, 3'd0, 8'h00);           // edge6: target captured
        chk("jmp_n2_valid", 32'(bus.ex_valid), 32'd0);
        step(1'b0, 3'd0, 8'h00);           // edge7: target on ex, self-loop in IF/ID
        chk("tgt_valid", 32'(bus.ex_valid), 32'd1);
        chk("tgt_rd",    32'(bus.ex_rd),    32'd7);
        chk("tgt_b",     32'(bus.ex_b),     32'h03);
        chk("loop_mj0",  32'(bus.mux_jump), 32'd1);
        begin
            logic exp_mj;
            exp_mj = 1'b1;
            for (int i = 0; i < 6; i++) begin
                step(1'b0, 3'd0, 8'h00);
                exp_mj = ~exp_mj;
                chk("loop_mj",    32'(bus.mux_jump), 32'(exp_mj));
                chk("loop_valid", 32'(bus.ex_valid), 32'd0);
            end
        end

        // mid-run reset: r5 held 33, must read back as 0
        mem[0] = 8'h2D;                    // ADD r5,r5
        async_reset("mid");
        step(1'b0, 3'd0, 8'h00);
        step(1'b0, 3'd0, 8'h00);
        chk("r5_valid", 32'(bus.ex_valid), 32'd1);
        chk("r5_rd",    32'(bus.ex_rd),    32'd5);
        chk("r5_a",     32'(bus.ex_a),     32'd0);
        chk("r5_b",     32'(bus.ex_b),     32'd0);

        // random programs and writebacks
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom));
            if (c == 200) async_reset("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
